// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state codes, opcodes and select encodings for the multicycle control unit
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_WB_ULA = 4'd5,
        ST_ADDR   = 4'd6,
        ST_MEM_RD = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_MEM_WR = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JAL    = 4'd11,
        ST_HALT   = 4'd12
    } st_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_DW   = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [1:0] MUXA_PC     = 2'd0;
    localparam logic [1:0] MUXA_A      = 2'd1;
    localparam logic [1:0] MUXA_ZERO   = 2'd2;
    localparam logic [1:0] MUXA_PC_OLD = 2'd3;

    localparam logic [1:0] MUXB_B    = 2'd0;
    localparam logic [1:0] MUXB_FOUR = 2'd1;
    localparam logic [1:0] MUXB_IMM  = 2'd2;

    localparam logic [1:0] MUXR_ULA = 2'd0;
    localparam logic [1:0] MUXR_MDR = 2'd1;
    localparam logic [1:0] MUXR_PC  = 2'd2;

    localparam logic [2:0] ULA_ADD = 3'd0;
    localparam logic [2:0] ULA_SUB = 3'd1;
    localparam logic [2:0] ULA_AND = 3'd2;
    localparam logic [2:0] ULA_OR  = 3'd3;
    localparam logic [2:0] ULA_XOR = 3'd4;
    localparam logic [2:0] ULA_SLT = 3'd5;

    // Instruction class chosen at the end of DECODE; anything unsupported halts.
    function automatic st_t decode_next(input logic [6:0] op, input logic [2:0] f3);
        st_t nxt;
        nxt = ST_HALT;
        if (op == OP_R) begin
            nxt = ST_EXEC_R;
        end else if ((op == OP_IMM && f3 == F3_ADDI) || op == OP_LUI) begin
            nxt = ST_EXEC_I;
        end else if ((op == OP_LOAD || op == OP_STORE) && f3 == F3_DW) begin
            nxt = ST_ADDR;
        end else if (op == OP_BRANCH && (f3 == F3_BEQ || f3 == F3_BNE)) begin
            nxt = ST_BRANCH;
        end else if (op == OP_JAL) begin
            nxt = ST_JAL;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_ula_ctrl.sv
// rtl/cpu_ula_ctrl.sv - ULA operation select from state and instruction fields
module cpu_ula_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] ula_op,
    output logic       illegal
);

    always_comb begin
        ula_op  = ULA_ADD;
        illegal = 1'b0;
        case (state)
            ST_EXEC_R: begin
                if (opcode != OP_R) begin
                    illegal = 1'b1;
                end else begin
                    case ({funct3, funct7_5})
                        4'b000_0: ula_op = ULA_ADD;
                        4'b000_1: ula_op = ULA_SUB;
                        4'b111_0: ula_op = ULA_AND;
                        4'b110_0: ula_op = ULA_OR;
                        4'b100_0: ula_op = ULA_XOR;
                        4'b010_0: ula_op = ULA_SLT;
                        default:  illegal = 1'b1;
                    endcase
                end
            end
            ST_BRANCH: ula_op = ULA_SUB;
            default:   ula_op = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multicycle RV64I-subset control unit driving the datapath strobes
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       ula_zero,
    output logic       pc_write,
    output logic       pc_sel,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_addr_sel,
    output logic       a_load,
    output logic       b_load,
    output logic       ula_out_load,
    output logic       mdr_load,
    output logic       reg_write,
    output logic [1:0] mux_a_sel,
    output logic [1:0] mux_b_sel,
    output logic [1:0] mux_reg_sel,
    output logic [2:0] ula_op,
    output logic [3:0] stt,
    output logic       err
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    st_t        state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       ula_illegal;
    logic       taken;

    cpu_ula_ctrl u_ula_ctrl (
        .state    (state_q),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .ula_op   (ula_op),
        .illegal  (ula_illegal)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            wait_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign taken = (funct3 == F3_BEQ && ula_zero) || (funct3 == F3_BNE && !ula_zero);
    assign stt   = state_q;
    assign err   = (state_q == ST_HALT);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        a_load       = 1'b0;
        b_load       = 1'b0;
        ula_out_load = 1'b0;
        mdr_load     = 1'b0;
        reg_write    = 1'b0;
        mux_a_sel    = MUXA_PC;
        mux_b_sel    = MUXB_B;
        mux_reg_sel  = MUXR_ULA;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read = 1'b1;
                if (wait_cnt_q != 3'd0) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end else begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    mux_a_sel = MUXA_PC;
                    mux_b_sel = MUXB_FOUR;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_load       = 1'b1;
                b_load       = 1'b1;
                ula_out_load = 1'b1;
                mux_a_sel    = MUXA_PC_OLD;
                mux_b_sel    = MUXB_IMM;
                state_d      = decode_next(opcode, funct3);
            end
            ST_EXEC_R: begin
                if (ula_illegal) begin
                    state_d = ST_HALT;
                end else begin
                    mux_a_sel    = MUXA_A;
                    mux_b_sel    = MUXB_B;
                    ula_out_load = 1'b1;
                    state_d      = ST_WB_ULA;
                end
            end
            ST_EXEC_I: begin
                mux_a_sel    = (opcode == OP_LUI) ? MUXA_ZERO : MUXA_A;
                mux_b_sel    = MUXB_IMM;
                ula_out_load = 1'b1;
                state_d      = ST_WB_ULA;
            end
            ST_WB_ULA: begin
                reg_write   = 1'b1;
                mux_reg_sel = MUXR_ULA;
                state_d     = ST_FETCH;
            end
            ST_ADDR: begin
                mux_a_sel    = MUXA_A;
                mux_b_sel    = MUXB_IMM;
                ula_out_load = 1'b1;
                if (opcode == OP_LOAD) begin
                    state_d    = ST_MEM_RD;
                    wait_cnt_d = LAT;
                end else begin
                    state_d = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                mem_read     = 1'b1;
                mem_addr_sel = 1'b1;
                if (wait_cnt_q != 3'd0) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end else begin
                    mdr_load = 1'b1;
                    state_d  = ST_WB_MEM;
                end
            end
            ST_WB_MEM: begin
                reg_write   = 1'b1;
                mux_reg_sel = MUXR_MDR;
                state_d     = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write    = 1'b1;
                mem_addr_sel = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_BRANCH: begin
                mux_a_sel = MUXA_A;
                mux_b_sel = MUXB_B;
                pc_sel    = 1'b1;
                pc_write  = taken;
                state_d   = ST_FETCH;
            end
            ST_JAL: begin
                reg_write   = 1'b1;
                mux_reg_sel = MUXR_PC;
                pc_write    = 1'b1;
                pc_sel      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase

        // Every entry into FETCH restarts the memory wait.
        if (state_d == ST_FETCH && state_q != ST_FETCH) begin
            wait_cnt_d = LAT;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - randomized instruction traces for two latencies against a cycle trace model
module tb_cpu_ctrl_fsm;

    typedef logic [24:0] obs_t;
    typedef obs_t obs_q_t[$];

    localparam logic [10:0] PCW = 11'h400;
    localparam logic [10:0] PCS = 11'h200;
    localparam logic [10:0] IRW = 11'h100;
    localparam logic [10:0] MR  = 11'h080;
    localparam logic [10:0] MW  = 11'h040;
    localparam logic [10:0] MAS = 11'h020;
    localparam logic [10:0] AL  = 11'h010;
    localparam logic [10:0] BL  = 11'h008;
    localparam logic [10:0] UOL = 11'h004;
    localparam logic [10:0] MDL = 11'h002;
    localparam logic [10:0] RW  = 11'h001;
    localparam int NI        = 40;
    localparam int HALT_HOLD = 20;

    logic       clock = 1'b0;
    logic       reset_i  [2];
    logic [6:0] opcode_i [2];
    logic [2:0] funct3_i [2];
    logic       f75_i    [2];
    logic       uz_i     [2];
    obs_t       obs      [2];
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pc_write, pc_sel, ir_write, mem_read, mem_write, mem_addr_sel;
        logic       a_load, b_load, ula_out_load, mdr_load, reg_write, err;
        logic [1:0] mux_a_sel, mux_b_sel, mux_reg_sel;
        logic [2:0] ula_op;
        logic [3:0] stt;

        cpu_ctrl_fsm #(.MEM_LAT(g + 1)) u_dut (
            .clock        (clock),
            .reset        (reset_i[g]),
            .opcode       (opcode_i[g]),
            .funct3       (funct3_i[g]),
            .funct7_5     (f75_i[g]),
            .ula_zero     (uz_i[g]),
            .pc_write     (pc_write),
            .pc_sel       (pc_sel),
            .ir_write     (ir_write),
            .mem_read     (mem_read),
            .mem_write    (mem_write),
            .mem_addr_sel (mem_addr_sel),
            .a_load       (a_load),
            .b_load       (b_load),
            .ula_out_load (ula_out_load),
            .mdr_load     (mdr_load),
            .reg_write    (reg_write),
            .mux_a_sel    (mux_a_sel),
            .mux_b_sel    (mux_b_sel),
            .mux_reg_sel  (mux_reg_sel),
            .ula_op       (ula_op),
            .stt          (stt),
            .err          (err)
        );

        assign obs[g] = {pc_write, pc_sel, ir_write, mem_read, mem_write, mem_addr_sel,
                         a_load, b_load, ula_out_load, mdr_load, reg_write,
                         mux_a_sel, mux_b_sel, mux_reg_sel, ula_op, stt, err};
    end

    task automatic expect_eq(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t mk(input int st, input logic [10:0] s, input logic [1:0] ma,
                                input logic [1:0] mb, input logic [1:0] mr, input logic [2:0] op);
        logic [3:0] st4;
        st4 = st[3:0];
        return {s, ma, mb, mr, op, st4, (st == 12)};
    endfunction

    // Expected per-cycle outputs for one instruction, from FETCH until back at FETCH or halted.
    task automatic build(input int lat, input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic uz, output obs_q_t q, output bit halted);
        logic [2:0] aop;
        bit         legal;
        q = {};
        halted = 1'b0;
        for (int i = 0; i < lat; i++) q.push_back(mk(1, MR, 0, 0, 0, 0));
        q.push_back(mk(1, MR | IRW | PCW, 0, 1, 0, 0));
        q.push_back(mk(2, AL | BL | UOL, 3, 2, 0, 0));
        if (op == 7'b0110011) begin
            legal = 1'b1;
            aop = 3'd0;
            case ({f3, f75})
                4'b000_0: aop = 3'd0;
                4'b000_1: aop = 3'd1;
                4'b111_0: aop = 3'd2;
                4'b110_0: aop = 3'd3;
                4'b100_0: aop = 3'd4;
                4'b010_0: aop = 3'd5;
                default:  legal = 1'b0;
            endcase
            if (legal) begin
                q.push_back(mk(3, UOL, 1, 0, 0, aop));
                q.push_back(mk(5, RW, 0, 0, 0, 0));
            end else begin
                q.push_back(mk(3, 11'h0, 0, 0, 0, 0));
                halted = 1'b1;
            end
        end else if ((op == 7'b0010011 && f3 == 3'd0) || op == 7'b0110111) begin
            q.push_back(mk(4, UOL, (op == 7'b0110111) ? 2'd2 : 2'd1, 2, 0, 0));
            q.push_back(mk(5, RW, 0, 0, 0, 0));
        end else if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'd3) begin
            q.push_back(mk(6, UOL, 1, 2, 0, 0));
            if (op == 7'b0000011) begin
                for (int i = 0; i < lat; i++) q.push_back(mk(7, MR | MAS, 0, 0, 0, 0));
                q.push_back(mk(7, MR | MAS | MDL, 0, 0, 0, 0));
                q.push_back(mk(8, RW, 0, 0, 1, 0));
            end else begin
                q.push_back(mk(9, MW | MAS, 0, 0, 0, 0));
            end
        end else if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1)) begin
            q.push_back(mk(10, PCS | (((f3 == 3'd0) == uz) ? PCW : 11'h0), 1, 0, 0, 1));
        end else if (op == 7'b1101111) begin
            q.push_back(mk(11, RW | PCW | PCS, 0, 0, 2, 0));
        end else begin
            halted = 1'b1;
        end
        if (halted) begin
            for (int i = 0; i < HALT_HOLD; i++) q.push_back(mk(12, 11'h0, 0, 0, 0, 0));
        end
    endtask

    task automatic pick(input int n, output logic [6:0] op, output logic [2:0] f3,
                        output logic f75, output logic uz);
        int c;
        f3  = 3'($urandom_range(0, 7));
        f75 = ($urandom_range(0, 3) == 0);
        uz  = 1'($urandom_range(0, 1));
        op  = 7'b1101111;
        case (n)
            0: begin op = 7'b0010011; f3 = 3'd0; end
            1: begin op = 7'b1100011; f3 = 3'd0; uz = 1'b1; end
            2: begin op = 7'b1100011; f3 = 3'd0; uz = 1'b0; end
            3: begin op = 7'b0000011; f3 = 3'd3; end
            4: op = 7'b1110011;
            5: begin op = 7'b0000011; f3 = 3'd3; end
            default: begin
                c = $urandom_range(0, 9);
                case (c)
                    0: op = 7'b0110011;
                    1: begin op = 7'b0010011; if ($urandom_range(0, 3) != 0) f3 = 3'd0; end
                    2: op = 7'b0110111;
                    3: begin op = 7'b0000011; f3 = 3'd3; end
                    4: begin op = 7'b0100011; f3 = 3'd3; end
                    5: op = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
                    6, 9: begin
                        op = 7'b1100011;
                        if ($urandom_range(0, 4) != 0) f3 = 3'($urandom_range(0, 1));
                    end
                    7: op = 7'b1101111;
                    default: op = 7'($urandom);
                endcase
            end
        endcase
    endtask

    task automatic do_reset(input int idx, input int cycles);
        reset_i[idx] = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            #1 expect_eq($sformatf("dut%0d reset_low", idx), obs[idx], '0);
            @(negedge clock);
        end
        reset_i[idx] = 1'b1;
    endtask

    task automatic run_dut(input int idx, input int lat);
        obs_q_t     q;
        bit         halted, need_s0, abort;
        int         abort_at;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75, uz;
        do_reset(idx, 3);
        need_s0 = 1'b1;
        for (int n = 0; n < NI; n++) begin
            pick(n, op, f3, f75, uz);
            build(lat, op, f3, f75, uz, q, halted);
            abort = (op == 7'b0000011 && f3 == 3'd3) &&
                    (n == 5 || (n > 5 && $urandom_range(0, 3) == 0));
            // Second cycle of MEM_RD: fetch (lat+1), decode, addr, first MEM_RD cycle precede it.
            abort_at = lat + 4 + (need_s0 ? 1 : 0);
            if (need_s0) q.push_front('0);
            need_s0 = 1'b0;
            opcode_i[idx] = op;
            funct3_i[idx] = f3;
            f75_i[idx]    = f75;
            uz_i[idx]     = uz;
            for (int k = 0; k < q.size(); k++) begin
                #1 expect_eq($sformatf("dut%0d i%0d op%b c%0d", idx, n, op, k), obs[idx], q[k]);
                if (abort && k == abort_at) begin
                    #2 reset_i[idx] = 1'b0;
                    #1 expect_eq($sformatf("dut%0d i%0d async_abort", idx, n), obs[idx], '0);
                    @(negedge clock);
                    break;
                end
                @(negedge clock);
            end
            if (abort) begin
                do_reset(idx, 2);
                need_s0 = 1'b1;
            end else if (halted) begin
                do_reset(idx, 3);
                need_s0 = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset_i[i]  = 1'b0;
            opcode_i[i] = '0;
            funct3_i[i] = '0;
            f75_i[i]    = 1'b0;
            uz_i[i]     = 1'b0;
        end
        @(negedge clock);
        fork
            run_dut(0, 1);
            run_dut(1, 2);
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
